// File: rtl/stim_ctrl_gen.sv
// rtl/stim_ctrl_gen.sv - cycle-exact generator of derived clock, periodic reset and enable
//
// Purpose: produces three registered bench-control signals from a single clock.
//   clk_gen : square wave, CLK_HALF clk cycles per half-period, first rise on edge CLK_HALF
//   rst_gen : low for RST_OFF edges, then high for RST_ON edges, repeating
//   en_gen  : high for EN_ON edges, then low for EN_OFF edges, repeating
// Ports:
//   clk     in   sole clock, rising edge
//   reset   in   synchronous active-low reset (wins over run and restart)
//   run     in   1 = generators advance, 0 = everything holds
//   restart in   one-cycle pulse, reloads the reset state
//   clk_gen out  derived clock (a flop output, not a real clock net)
//   rst_gen out  periodic active-high reset pulse
//   en_gen  out  periodic active-high enable
module stim_ctrl_gen #(
  parameter int CNT_W    = 16,
  parameter int CLK_HALF = 10,
  parameter int RST_OFF  = 30,
  parameter int RST_ON   = 15,
  parameter int EN_ON    = 40,
  parameter int EN_OFF   = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic clk_gen,
  output logic rst_gen,
  output logic en_gen
);

  // A zero-length phase would never end, so it is stretched to one cycle.
  localparam int CLK_L     = (CLK_HALF == 0) ? 1 : CLK_HALF;
  localparam int RST_OFF_L = (RST_OFF  == 0) ? 1 : RST_OFF;
  localparam int RST_ON_L  = (RST_ON   == 0) ? 1 : RST_ON;
  localparam int EN_ON_L   = (EN_ON    == 0) ? 1 : EN_ON;
  localparam int EN_OFF_L  = (EN_OFF   == 0) ? 1 : EN_OFF;

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (longint'(CLK_HALF) > CNT_MAX || longint'(RST_OFF) > CNT_MAX ||
      longint'(RST_ON) > CNT_MAX || longint'(EN_ON) > CNT_MAX ||
      longint'(EN_OFF) > CNT_MAX) begin : g_param_check
    $error("stim_ctrl_gen: phase length does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CLK_LAST     = CNT_W'(CLK_L - 1);
  localparam logic [CNT_W-1:0] RST_OFF_LAST = CNT_W'(RST_OFF_L - 1);
  localparam logic [CNT_W-1:0] RST_ON_LAST  = CNT_W'(RST_ON_L - 1);
  localparam logic [CNT_W-1:0] EN_ON_LAST   = CNT_W'(EN_ON_L - 1);
  localparam logic [CNT_W-1:0] EN_OFF_LAST  = CNT_W'(EN_OFF_L - 1);

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } phase_e;

  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic             clk_gen_q, clk_gen_d;

  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  phase_e           rst_ph_q,  rst_ph_d;
  logic             rst_gen_q, rst_gen_d;
  logic [CNT_W-1:0] rst_last;

  logic [CNT_W-1:0] en_cnt_q, en_cnt_d;
  phase_e           en_ph_q,  en_ph_d;
  logic             en_gen_q, en_gen_d;
  logic [CNT_W-1:0] en_last;

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    clk_gen_d = clk_gen_q;
    rst_cnt_d = rst_cnt_q;
    rst_ph_d  = rst_ph_q;
    rst_gen_d = rst_gen_q;
    en_cnt_d  = en_cnt_q;
    en_ph_d   = en_ph_q;
    en_gen_d  = en_gen_q;
    rst_last  = (rst_ph_q == PH_ON) ? RST_ON_LAST : RST_OFF_LAST;
    en_last   = (en_ph_q  == PH_ON) ? EN_ON_LAST  : EN_OFF_LAST;

    if (run) begin
      // clk_gen flips on the same edge its counter wraps.
      if (clk_cnt_q == CLK_LAST) begin
        clk_cnt_d = '0;
        clk_gen_d = ~clk_gen_q;
      end else begin
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
      end

      // rst/en outputs show the phase in force before this edge's update,
      // so the last edge of a phase still presents that phase and the
      // reset-state output value (high) is independent of the phase bit.
      rst_gen_d = (rst_ph_q == PH_ON);
      if (rst_cnt_q == rst_last) begin
        rst_cnt_d = '0;
        rst_ph_d  = (rst_ph_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        rst_cnt_d = rst_cnt_q + CNT_W'(1);
      end

      en_gen_d = (en_ph_q == PH_ON);
      if (en_cnt_q == en_last) begin
        en_cnt_d = '0;
        en_ph_d  = (en_ph_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        en_cnt_d = en_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || restart) begin
      clk_cnt_q <= '0;
      clk_gen_q <= 1'b0;
      rst_cnt_q <= '0;
      rst_ph_q  <= PH_OFF;
      rst_gen_q <= 1'b1;
      en_cnt_q  <= '0;
      en_ph_q   <= PH_ON;
      en_gen_q  <= 1'b1;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      clk_gen_q <= clk_gen_d;
      rst_cnt_q <= rst_cnt_d;
      rst_ph_q  <= rst_ph_d;
      rst_gen_q <= rst_gen_d;
      en_cnt_q  <= en_cnt_d;
      en_ph_q   <= en_ph_d;
      en_gen_q  <= en_gen_d;
    end
  end

  assign clk_gen = clk_gen_q;
  assign rst_gen = rst_gen_q;
  assign en_gen  = en_gen_q;

endmodule

// File: tb/tb_stim_ctrl_gen.sv
// tb/tb_stim_ctrl_gen.sv - directed bench for stim_ctrl_gen with default parameters
module tb_stim_ctrl_gen;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic run     = 1'b0;
  logic restart = 1'b0;
  logic clk_gen;
  logic rst_gen;
  logic en_gen;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   e;
    logic c;
    logic r;
    logic n;
  } vec_t;

  vec_t tab[$];

  stim_ctrl_gen dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .restart(restart),
    .clk_gen(clk_gen),
    .rst_gen(rst_gen),
    .en_gen (en_gen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic c, input logic r, input logic n);
    chk({tag, ".clk_gen"}, clk_gen, c);
    chk({tag, ".rst_gen"}, rst_gen, r);
    chk({tag, ".en_gen"},  en_gen,  n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    run     = 1'b1;
    restart = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
  endtask

  initial begin
    // Hand-computed outputs for default parameters, edge numbered from release.
    tab.push_back('{9,   1'b0, 1'b0, 1'b1});
    tab.push_back('{10,  1'b1, 1'b0, 1'b1});
    tab.push_back('{19,  1'b1, 1'b0, 1'b1});
    tab.push_back('{20,  1'b0, 1'b0, 1'b1});
    tab.push_back('{30,  1'b1, 1'b0, 1'b1});
    tab.push_back('{31,  1'b1, 1'b1, 1'b1});
    tab.push_back('{40,  1'b0, 1'b1, 1'b1});
    tab.push_back('{41,  1'b0, 1'b1, 1'b0});
    tab.push_back('{45,  1'b0, 1'b1, 1'b0});
    tab.push_back('{46,  1'b0, 1'b0, 1'b0});
    tab.push_back('{50,  1'b1, 1'b0, 1'b0});
    tab.push_back('{55,  1'b1, 1'b0, 1'b0});
    tab.push_back('{56,  1'b1, 1'b0, 1'b1});
    tab.push_back('{60,  1'b0, 1'b0, 1'b1});
    tab.push_back('{75,  1'b1, 1'b0, 1'b1});
    tab.push_back('{76,  1'b1, 1'b1, 1'b1});
    tab.push_back('{90,  1'b1, 1'b1, 1'b1});
    tab.push_back('{91,  1'b1, 1'b0, 1'b1});
    tab.push_back('{100, 1'b0, 1'b0, 1'b0});

    // Reset state, then first edge after release.
    do_reset();
    chk3("reset", 1'b0, 1'b1, 1'b1);
    tick();
    chk3("e1", 1'b0, 1'b0, 1'b1);

    // Free run to edge 100 against the table.
    for (int n = 2; n <= 100; n++) begin
      tick();
      foreach (tab[k]) begin
        if (tab[k].e == n) chk3($sformatf("run e%0d", n), tab[k].c, tab[k].r, tab[k].n);
      end
    end

    // run=0 on edges 12..17 freezes everything; phases resume 6 edges late.
    do_reset();
    for (int n = 1; n <= 11; n++) tick();
    chk3("hold e11", 1'b1, 1'b0, 1'b1);
    run = 1'b0;
    for (int n = 12; n <= 17; n++) begin
      tick();
      chk3($sformatf("hold e%0d", n), 1'b1, 1'b0, 1'b1);
    end
    run = 1'b1;
    for (int n = 18; n <= 37; n++) begin
      tick();
      if (n == 25) chk("hold e25.clk_gen", clk_gen, 1'b1);
      if (n == 26) chk("hold e26.clk_gen", clk_gen, 1'b0);
      if (n == 36) chk("hold e36.rst_gen", rst_gen, 1'b0);
      if (n == 37) chk("hold e37.rst_gen", rst_gen, 1'b1);
    end

    // restart pulse at edge 37; edge 38 behaves as edge 1.
    do_reset();
    for (int n = 1; n <= 36; n++) tick();
    chk3("rs e36", 1'b1, 1'b1, 1'b1);
    restart = 1'b1;
    run     = 1'b0;
    tick();
    chk3("rs e37", 1'b0, 1'b1, 1'b1);
    restart = 1'b0;
    run     = 1'b1;
    tick();
    chk3("rs e38", 1'b0, 1'b0, 1'b1);
    repeat (8) tick();
    chk("rs e46.clk_gen", clk_gen, 1'b0);
    tick();
    chk("rs e47.clk_gen", clk_gen, 1'b1);

    // reset at edge 33 with clk_gen and rst_gen high, then sequence restarts.
    do_reset();
    for (int n = 1; n <= 32; n++) tick();
    chk3("rl e32", 1'b1, 1'b1, 1'b1);
    reset   = 1'b0;
    restart = 1'b0;
    tick();
    chk3("rl e33", 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    chk3("rl post e1", 1'b0, 1'b0, 1'b1);
    repeat (9) tick();
    chk("rl post e10.clk_gen", clk_gen, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
